isa_cycle_gen: RTL and testbench
================================

# isa_cycle_gen

ISA bus initiator that turns single-beat CPU-side requests into timed ISA I/O and memory read/write cycles (address setup, strobe, wait-state extension, hold). It drives the same bus signals that the video cards and other ISA responders in the design decode (`bus_a`, `bus_ior_l`, `bus_iow_l`, `bus_memr_l`, `bus_memw_l`, `bus_aen`, `bus_d`) and returns read data together with a completion/error response. It sits between the CPU core's bus unit and the ISA peripheral fabric.

## Interface
- `SETUP_CYCLES`, 1: clocks of address-valid before the strobe; range 1..15.
- `STROBE_CYCLES`, 4: minimum strobe-low clocks; range 1..15.
- `HOLD_CYCLES`, 1: clocks of address/data hold after the strobe; range 0..15.
- `RDY_TIMEOUT`, 255: maximum extra strobe clocks with `bus_rdy` low; range 1..255.
- `clk  in  1  system clock`
- `reset  in  1  synchronous, active-high reset`
- `req_valid  in  1  request present`
- `req_ready  out  1  request accepted when high with req_valid`
- `req_cmd  in  2  0=IOR, 1=IOW, 2=MEMR, 3=MEMW`
- `req_addr  in  20  byte address; IO commands use [15:0]`
- `req_wdata  in  8  write data`
- `rsp_valid  out  1  one-clock completion pulse`
- `rsp_rdata  out  8  read data; valid with rsp_valid on reads`
- `rsp_err  out  1  rdy timeout; valid with rsp_valid`
- `bus_a  out  20  ISA address`
- `bus_aen  out  1  high = no CPU cycle (responders ignore decode)`
- `bus_ior_l`, `bus_iow_l`, `bus_memr_l`, `bus_memw_l  out  1 each  active-low strobes`
- `bus_d  out  8  write data`
- `bus_d_oe  out  1  high while driving bus_d`
- `bus_din  in  8  responder read data`
- `bus_dir  in  1  responder driving bus_din`
- `bus_rdy  in  1  low = insert wait state`

## Operation
- States: IDLE, SETUP, STROBE, HOLD. All bus outputs registered.
- IDLE: `req_ready`=1. On `req_valid & req_ready`: latch cmd/addr/wdata, drive `bus_a` (IO: `{4'h0, addr[15:0]}`), `bus_aen`=0, `bus_d`/`bus_d_oe`=1 for writes, go to SETUP with counter = `SETUP_CYCLES`.
- SETUP: strobes high; after `SETUP_CYCLES` clocks enter STROBE, asserting the one strobe selected by cmd.
- STROBE: counts `STROBE_CYCLES`. After the minimum, exits on the first clock where `bus_rdy`=1 (sampled). Each clock with `bus_rdy`=0 past the minimum increments the wait counter; reaching `RDY_TIMEOUT` forces exit with error flag set.
- On STROBE exit edge: reads latch `bus_dir ? bus_din : 8'hFF` (undriven bus reads FF); strobe deasserts; `rsp_valid` pulses one clock with `rsp_rdata` and `rsp_err`.
- HOLD: address, `bus_aen`=0 and write data held `HOLD_CYCLES` clocks, then `bus_aen`=1, `bus_d_oe`=0, back to IDLE. `HOLD_CYCLES`=0 skips HOLD.
- `rsp_rdata` is 8'h00 on writes; retains value only during the pulse.
- Exactly one strobe low at any time; never low outside STROBE.

## Timing
- Reset values: `req_ready`=0 during reset, 1 the clock after; `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0; `bus_a`=0, `bus_aen`=1, all strobes=1, `bus_d`=0, `bus_d_oe`=0.
- Defaults, `bus_rdy`=1: accept at edge 0; strobe low edges 1..5 (4 clocks); `rsp_valid` high clock 5..6; IDLE/`req_ready` again at edge 6. Back-to-back issue: next request accepted at edge 6.
- Each `bus_rdy`=0 clock in the final minimum STROBE clock or later adds one clock.
- Reset mid-cycle: on the reset edge all strobes deassert, `bus_aen`=1, `bus_d_oe`=0, no `rsp_valid`; request is dropped.
- `req_*` ignored outside IDLE; no internal queueing.

## Structure
- Shared package `isa_pkg`: command encoding localparams (`ISA_IOR`..`ISA_MEMW`), state encoding, and `ISA_FLOAT_DATA`=8'hFF.
- Single module; no sub-module needed. Counters: 4-bit phase counter, 8-bit wait counter.

## Test plan
- IOW to 0x3D8, data 0x29, defaults -> `bus_iow_l` low exactly 4 clocks, `bus_a`=0x003D8, `bus_d`=0x29 with `bus_d_oe` for SETUP+STROBE+HOLD, `rsp_valid` one clock, `rsp_err`=0.
- IOR 0x3DA with responder `bus_dir`=1, `bus_din`=0xF9 -> `rsp_rdata`=0xF9; IOR to unmapped 0x300 (`bus_dir`=0) -> `rsp_rdata`=0xFF.
- MEMR 0xB8000, `bus_rdy` low 3 clocks from strobe start+2 -> strobe low 5 clocks, data latched after `bus_rdy` rises.
- `RDY_TIMEOUT`=8, `bus_rdy` held low -> strobe released after 4+8 clocks, `rsp_err`=1, bus returns to idle.
- Two back-to-back MEMW with `req_valid` held -> second accepted exactly 6 clocks after first; never two strobes low.
- `reset` asserted during STROBE of IOW -> next clock `bus_iow_l`=1, `bus_aen`=1, `bus_d_oe`=0, no `rsp_valid`.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA bus definitions: command encoding, initiator state encoding and
// the value an undriven data bus reads back as.
package isa_pkg;

  localparam logic [1:0] ISA_IOR  = 2'd0;
  localparam logic [1:0] ISA_IOW  = 2'd1;
  localparam logic [1:0] ISA_MEMR = 2'd2;
  localparam logic [1:0] ISA_MEMW = 2'd3;

  localparam logic [7:0] ISA_FLOAT_DATA = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } isa_state_e;

  // Bit 0 of the command separates writes from reads, bit 1 memory from IO.
  function automatic logic is_write(input logic [1:0] cmd);
    return cmd[0];
  endfunction

  function automatic logic is_io(input logic [1:0] cmd);
    return ~cmd[1];
  endfunction

endpackage

// File: rtl/isa_cycle_gen.sv
// ISA bus initiator: turns one CPU-side request into a timed ISA IO or memory
// cycle (setup, strobe with bus_rdy wait states, hold) and returns a response.
module isa_cycle_gen
  import isa_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1,
  parameter int RDY_TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_cmd,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [19:0] bus_a,
  output logic        bus_aen,
  output logic        bus_ior_l,
  output logic        bus_iow_l,
  output logic        bus_memr_l,
  output logic        bus_memw_l,
  output logic [7:0]  bus_d,
  output logic        bus_d_oe,
  input  logic [7:0]  bus_din,
  input  logic        bus_dir,
  input  logic        bus_rdy
);

  isa_state_e  state_q, state_d;
  logic [3:0]  phase_q, phase_d;
  logic [7:0]  wait_q, wait_d;
  logic [1:0]  cmd_q, cmd_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [19:0] bus_a_q, bus_a_d;
  logic        bus_aen_q, bus_aen_d;
  logic [3:0]  strb_l_q, strb_l_d;   // active-low strobes indexed by command
  logic [7:0]  bus_d_q, bus_d_d;
  logic        bus_d_oe_q, bus_d_oe_d;
  logic        accept, go_idle;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    wait_d      = wait_q;
    cmd_d       = cmd_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 8'h00;
    rsp_err_d   = 1'b0;
    bus_a_d     = bus_a_q;
    bus_aen_d   = bus_aen_q;
    strb_l_d    = strb_l_q;
    bus_d_d     = bus_d_q;
    bus_d_oe_d  = bus_d_oe_q;
    go_idle     = 1'b0;
    accept      = req_valid & req_ready_q;

    unique case (state_q)
      ST_IDLE: req_ready_d = 1'b1;

      ST_SETUP: begin
        if (phase_q <= 4'd1) begin
          state_d  = ST_STROBE;
          phase_d  = 4'(STROBE_CYCLES);
          strb_l_d = ~(4'b0001 << cmd_q);
        end else begin
          phase_d = phase_q - 4'd1;
        end
      end

      ST_STROBE: begin
        if (phase_q > 4'd1) begin
          phase_d = phase_q - 4'd1;
        end else if (bus_rdy || (wait_q >= 8'(RDY_TIMEOUT))) begin
          strb_l_d    = 4'hF;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ~bus_rdy;
          if (!is_write(cmd_q)) rsp_rdata_d = bus_dir ? bus_din : ISA_FLOAT_DATA;
          if (HOLD_CYCLES == 0) begin
            go_idle = 1'b1;
          end else begin
            state_d     = ST_HOLD;
            phase_d     = 4'(HOLD_CYCLES);
            req_ready_d = (HOLD_CYCLES == 1);
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      ST_HOLD: begin
        // Ready rises for the final hold clock so a back-to-back request is
        // taken on the same edge the bus would otherwise return to idle.
        if (phase_q <= 4'd1) begin
          go_idle = 1'b1;
        end else begin
          phase_d     = phase_q - 4'd1;
          req_ready_d = (phase_q == 4'd2);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (go_idle) begin
      state_d     = ST_IDLE;
      bus_aen_d   = 1'b1;
      bus_d_oe_d  = 1'b0;
      bus_d_d     = 8'h00;
      req_ready_d = 1'b1;
    end

    if (accept) begin
      state_d     = ST_SETUP;
      phase_d     = 4'(SETUP_CYCLES);
      wait_d      = 8'h00;
      cmd_d       = req_cmd;
      bus_a_d     = is_io(req_cmd) ? {4'h0, req_addr[15:0]} : req_addr;
      bus_aen_d   = 1'b0;
      bus_d_d     = is_write(req_cmd) ? req_wdata : 8'h00;
      bus_d_oe_d  = is_write(req_cmd);
      req_ready_d = 1'b0;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= 4'd0;
      wait_q      <= 8'd0;
      cmd_q       <= ISA_IOR;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
      bus_a_q     <= 20'h0;
      bus_aen_q   <= 1'b1;
      strb_l_q    <= 4'hF;
      bus_d_q     <= 8'h00;
      bus_d_oe_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      wait_q      <= wait_d;
      cmd_q       <= cmd_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      bus_a_q     <= bus_a_d;
      bus_aen_q   <= bus_aen_d;
      strb_l_q    <= strb_l_d;
      bus_d_q     <= bus_d_d;
      bus_d_oe_q  <= bus_d_oe_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign bus_a      = bus_a_q;
  assign bus_aen    = bus_aen_q;
  assign bus_ior_l  = strb_l_q[ISA_IOR];
  assign bus_iow_l  = strb_l_q[ISA_IOW];
  assign bus_memr_l = strb_l_q[ISA_MEMR];
  assign bus_memw_l = strb_l_q[ISA_MEMW];
  assign bus_d      = bus_d_q;
  assign bus_d_oe   = bus_d_oe_q;

endmodule

// File: tb/tb_isa_cycle_gen.sv
// Self-checking bench for isa_cycle_gen: directed scenarios plus randomized
// cycles compared against a transaction-level model of the bus timing.
module tb_isa_cycle_gen;
  import isa_pkg::*;

  localparam int SETUP = 1, STROBE = 4, HOLD = 1, TO_A = 255, TO_T = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1, req_valid = 1'b0, bus_dir = 1'b0, bus_rdy = 1'b1;
  logic [1:0]  req_cmd = 2'd0;
  logic [19:0] req_addr = 20'h0;
  logic [7:0]  req_wdata = 8'h00, bus_din = 8'h00;

  logic        a_ready, a_rv, a_err, a_aen, a_ior, a_iow, a_memr, a_memw, a_doe;
  logic [7:0]  a_rdata, a_d;
  logic [19:0] a_a;
  logic        t_ready, t_rv, t_err, t_aen, t_ior, t_iow, t_memr, t_memw, t_doe;
  logic [7:0]  t_rdata, t_d;
  logic [19:0] t_a;

  isa_cycle_gen #(.SETUP_CYCLES(SETUP), .STROBE_CYCLES(STROBE), .HOLD_CYCLES(HOLD),
                  .RDY_TIMEOUT(TO_A)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(a_ready),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_rv), .rsp_rdata(a_rdata), .rsp_err(a_err), .bus_a(a_a),
    .bus_aen(a_aen), .bus_ior_l(a_ior), .bus_iow_l(a_iow), .bus_memr_l(a_memr),
    .bus_memw_l(a_memw), .bus_d(a_d), .bus_d_oe(a_doe), .bus_din(bus_din),
    .bus_dir(bus_dir), .bus_rdy(bus_rdy));

  isa_cycle_gen #(.SETUP_CYCLES(SETUP), .STROBE_CYCLES(STROBE), .HOLD_CYCLES(HOLD),
                  .RDY_TIMEOUT(TO_T)) dut_t (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(t_ready),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(t_rv), .rsp_rdata(t_rdata), .rsp_err(t_err), .bus_a(t_a),
    .bus_aen(t_aen), .bus_ior_l(t_ior), .bus_iow_l(t_iow), .bus_memr_l(t_memr),
    .bus_memw_l(t_memw), .bus_d(t_d), .bus_d_oe(t_doe), .bus_din(bus_din),
    .bus_dir(bus_dir), .bus_rdy(bus_rdy));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  strb_l;  // {memw, memr, iow, ior}
    logic [19:0] a;
    logic        aen, d_oe, rv, err, rdy;
    logic [7:0]  d, rdata;
  } obs_t;

  typedef struct packed {
    int low_first, low_cnt, bad_strobe, rv_idx, rv_cnt, rdata, err;
    int aen_low, doe_cnt, a_bad, d_bad, ready_idx;
  } meas_t;

  int   errors = 0, checks = 0, multi_low = 0;
  obs_t obs [64];
  logic rdy_at [64];
  logic [7:0] din_at [64];

  always @(negedge clk)
    if (($countones(~{a_memw, a_memr, a_iow, a_ior}) > 1) ||
        ($countones(~{t_memw, t_memr, t_iow, t_ior}) > 1))
      multi_low <= multi_low + 1;

  function automatic obs_t sample(input int sel);
    obs_t o;
    if (sel != 0) begin
      o.strb_l = {t_memw, t_memr, t_iow, t_ior}; o.a = t_a; o.aen = t_aen;
      o.d = t_d; o.d_oe = t_doe; o.rv = t_rv; o.rdata = t_rdata; o.err = t_err; o.rdy = t_ready;
    end else begin
      o.strb_l = {a_memw, a_memr, a_iow, a_ior}; o.a = a_a; o.aen = a_aen;
      o.d = a_d; o.d_oe = a_doe; o.rv = a_rv; o.rdata = a_rdata; o.err = a_err; o.rdy = a_ready;
    end
    return o;
  endfunction

  function automatic string fmt(input meas_t m);
    return $sformatf("first=%0d low=%0d bad=%0d rv=%0d@%0d rd=%02h err=%0d aen_low=%0d oe=%0d abad=%0d dbad=%0d rdy@%0d",
      m.low_first, m.low_cnt, m.bad_strobe, m.rv_cnt, m.rv_idx, m.rdata, m.err,
      m.aen_low, m.doe_cnt, m.a_bad, m.d_bad, m.ready_idx);
  endfunction

  // rdy_at[k] is the bus_rdy level seen at edge k after the accepting edge 0.
  task automatic set_rdy(input int from, input int len);
    for (int k = 0; k < 64; k++) rdy_at[k] = !(k >= from && k < from + len);
  endtask

  // Reference: the strobe may end at the first edge from SETUP+STROBE onward
  // with rdy high, but no later than TIMEOUT edges past that point (error).
  function automatic int exit_of(input int to);
    int  ex = SETUP + STROBE + to;
    bit  found = 0;
    for (int e = SETUP + STROBE; e <= SETUP + STROBE + to && e < 64; e++)
      if (!found && rdy_at[e]) begin ex = e; found = 1; end
    return ex;
  endfunction

  function automatic logic [19:0] exp_addr(input logic [1:0] cmd, input logic [19:0] addr);
    return (cmd == ISA_IOR || cmd == ISA_IOW) ? {4'h0, addr[15:0]} : addr;
  endfunction

  function automatic meas_t model(input int to, input logic [1:0] cmd, input logic dir);
    meas_t e;
    int    ex = exit_of(to);
    bit    rd = (cmd == ISA_IOR || cmd == ISA_MEMR);
    e = '0;
    e.low_first = SETUP;
    e.low_cnt   = ex - SETUP;
    e.rv_idx    = ex;
    e.rv_cnt    = 1;
    e.rdata     = rd ? (dir ? int'(din_at[ex]) : int'(ISA_FLOAT_DATA)) : 0;
    e.err       = (ex == SETUP + STROBE + to && !rdy_at[ex]) ? 1 : 0;
    e.aen_low   = ex + HOLD;
    e.doe_cnt   = rd ? 0 : ex + HOLD;
    e.ready_idx = ex + HOLD - 1;
    return e;
  endfunction

  function automatic meas_t measure(input int n, input logic [1:0] cmd,
                                    input logic [19:0] ea, input logic [7:0] wd);
    meas_t m;
    logic [3:0] sel_l = ~(4'b0001 << cmd);
    m = '0; m.low_first = -1; m.rv_idx = -1; m.ready_idx = -1;
    for (int i = 0; i < n; i++) begin
      if (obs[i].strb_l !== 4'hF && m.low_first < 0) m.low_first = i;
      if (obs[i].strb_l === sel_l) m.low_cnt++;
      else if (obs[i].strb_l !== 4'hF) m.bad_strobe++;
      if (obs[i].rv === 1'b1) begin
        m.rv_cnt++;
        if (m.rv_idx < 0) begin m.rv_idx = i; m.rdata = int'(obs[i].rdata); m.err = int'(obs[i].err); end
      end
      if (obs[i].aen === 1'b0) begin m.aen_low++; if (obs[i].a !== ea) m.a_bad++; end
      if (obs[i].d_oe === 1'b1) begin m.doe_cnt++; if (obs[i].d !== wd) m.d_bad++; end
      if (obs[i].rdy === 1'b1 && m.ready_idx < 0) m.ready_idx = i;
    end
    return m;
  endfunction

  task automatic wait_accept(input int sel, output bit ok);
    logic r;
    ok = 0;
    for (int w = 0; w < 20 && !ok; w++) begin
      @(negedge clk); r = (sel != 0) ? t_ready : a_ready;
      @(posedge clk); if (r === 1'b1) ok = 1;
    end
  endtask

  task automatic do_txn(input int sel, input logic [1:0] cmd, input logic [19:0] addr,
                        input logic [7:0] wd, input logic dir, input int din_fix,
                        input int ncyc, output bit ok);
    #1; req_valid = 1; req_cmd = cmd; req_addr = addr; req_wdata = wd;
    bus_dir = dir; bus_rdy = 1;
    wait_accept(sel, ok);
    if (ok) begin
      for (int k = 0; k < ncyc; k++) begin
        #1; req_valid = 0;
        din_at[k+1] = (din_fix >= 0) ? 8'(din_fix) : 8'($urandom);
        bus_din = din_at[k+1]; bus_rdy = rdy_at[k+1];
        @(negedge clk); obs[k] = sample(sel);
        @(posedge clk);
      end
    end
    #1; req_valid = 0; bus_rdy = 1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1;
    @(posedge clk); @(posedge clk); #1 reset = 0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    obs_t o;
    @(posedge clk); @(posedge clk);
    for (int s = 0; s < 2; s++) begin
      @(negedge clk); o = sample(s);
      checks++;
      if ({o.rdy, o.rv, o.rdata, o.err, o.a, o.aen, o.strb_l, o.d, o.d_oe} !==
          {1'b0, 1'b0, 8'h00, 1'b0, 20'h0, 1'b1, 4'hF, 8'h00, 1'b0}) begin
        errors++;
        $display("FAIL reset_values inst%0d: rdy=%b rv=%b rd=%h err=%b a=%h aen=%b strb=%b d=%h oe=%b",
                 s, o.rdy, o.rv, o.rdata, o.err, o.a, o.aen, o.strb_l, o.d, o.d_oe);
      end
    end
    @(posedge clk); #1 reset = 0;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({a_ready, t_ready} !== 2'b11) begin
      errors++; $display("FAIL ready_after_reset: got %b want 11", {a_ready, t_ready});
    end
  endtask

  task automatic test_iow();
    meas_t m, e; bit ok;
    set_rdy(0, 0);
    do_txn(0, ISA_IOW, 20'h003D8, 8'h29, 1'b0, -1, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL iow_accept: no handshake"); end
    e = model(TO_A, ISA_IOW, 1'b0);
    m = measure(10, ISA_IOW, 20'h003D8, 8'h29);
    checks++; if (m.low_cnt !== 4) begin errors++; $display("FAIL iow_strobe_len: got %0d want 4", m.low_cnt); end
    checks++; if (m.a_bad !== 0 || m.d_bad !== 0) begin
      errors++; $display("FAIL iow_addr_data: bad addr %0d bad data %0d want 0", m.a_bad, m.d_bad); end
    checks++; if (m.doe_cnt !== SETUP + STROBE + HOLD) begin
      errors++; $display("FAIL iow_d_oe_len: got %0d want %0d", m.doe_cnt, SETUP + STROBE + HOLD); end
    checks++; if (m !== e) begin errors++; $display("FAIL iow_cycle: got %s want %s", fmt(m), fmt(e)); end
  endtask

  task automatic test_ior();
    meas_t m, e; bit ok;
    set_rdy(0, 0);
    do_txn(0, ISA_IOR, 20'hA03DA, 8'h00, 1'b1, 8'hF9, 10, ok);
    e = model(TO_A, ISA_IOR, 1'b1);
    m = measure(10, ISA_IOR, 20'h003DA, 8'h00);
    checks++; if (m.rdata !== 32'hF9) begin errors++; $display("FAIL ior_driven_data: got %02h want f9", m.rdata); end
    checks++; if (!ok || m !== e) begin errors++; $display("FAIL ior_cycle: got %s want %s", fmt(m), fmt(e)); end
    do_txn(0, ISA_IOR, 20'h00300, 8'h00, 1'b0, 8'h5A, 10, ok);
    m = measure(10, ISA_IOR, 20'h00300, 8'h00);
    checks++; if (!ok || m.rdata !== 32'hFF || m.rv_cnt !== 1) begin
      errors++; $display("FAIL ior_floating: got %02h x%0d want ff x1", m.rdata, m.rv_cnt); end
  endtask

  task automatic test_wait_states();
    meas_t m, e; bit ok; int ex;
    set_rdy(3, 3);
    ex = exit_of(TO_A);
    do_txn(0, ISA_MEMR, 20'hB8000, 8'h00, 1'b1, -1, ex + HOLD + 3, ok);
    e = model(TO_A, ISA_MEMR, 1'b1);
    m = measure(ex + HOLD + 3, ISA_MEMR, 20'hB8000, 8'h00);
    checks++; if (m.low_cnt !== 5) begin errors++; $display("FAIL memr_wait_len: got %0d want 5", m.low_cnt); end
    checks++; if (!ok || m !== e) begin errors++; $display("FAIL memr_wait_cycle: got %s want %s", fmt(m), fmt(e)); end
  endtask

  task automatic test_timeout();
    meas_t m, e; bit ok; int ex;
    do_reset();
    set_rdy(1, 100);
    ex = exit_of(TO_T);
    do_txn(1, ISA_IOR, 20'h00201, 8'h00, 1'b1, -1, ex + HOLD + 3, ok);
    e = model(TO_T, ISA_IOR, 1'b1);
    m = measure(ex + HOLD + 3, ISA_IOR, 20'h00201, 8'h00);
    checks++; if (m.low_cnt !== STROBE + TO_T || m.err !== 1) begin
      errors++; $display("FAIL timeout_len_err: got low=%0d err=%0d want %0d 1", m.low_cnt, m.err, STROBE + TO_T); end
    checks++; if (!ok || m !== e) begin errors++; $display("FAIL timeout_cycle: got %s want %s", fmt(m), fmt(e)); end
    checks++; if (obs[ex + HOLD].aen !== 1'b1 || obs[ex + HOLD].strb_l !== 4'hF) begin
      errors++; $display("FAIL timeout_idle: aen=%b strb=%b want 1 1111", obs[ex + HOLD].aen, obs[ex + HOLD].strb_l); end
    do_reset();
  endtask

  task automatic test_back_to_back();
    bit ok, acc2 = 0; int gap = -1, lowc = 0; logic r;
    #1; req_valid = 1; req_cmd = ISA_MEMW; req_addr = 20'hC1234; req_wdata = 8'h3C; bus_rdy = 1;
    wait_accept(0, ok);
    #1; req_addr = 20'hD5678; req_wdata = 8'hA7;
    for (int w = 1; w <= 20 && !acc2; w++) begin
      @(negedge clk); r = a_ready; if (a_memw === 1'b0) lowc++;
      @(posedge clk); if (r === 1'b1) begin acc2 = 1; gap = w; end
    end
    #1; req_valid = 0;
    checks++; if (!ok || gap !== 6) begin errors++; $display("FAIL b2b_gap: got %0d want 6", gap); end
    checks++; if (lowc !== STROBE) begin errors++; $display("FAIL b2b_first_strobe: got %0d want %0d", lowc, STROBE); end
    @(negedge clk);
    checks++; if ({a_a, a_aen, a_d, a_doe} !== {20'hD5678, 1'b0, 8'hA7, 1'b1}) begin
      errors++; $display("FAIL b2b_second_bus: a=%h aen=%b d=%h oe=%b want d5678 0 a7 1", a_a, a_aen, a_d, a_doe); end
    repeat (10) @(posedge clk);
  endtask

  task automatic test_random();
    meas_t m, e; bit ok; int ex; logic [1:0] cmd; logic [19:0] addr; logic [7:0] wd; logic dir;
    for (int n = 0; n < 24; n++) begin
      cmd = 2'($urandom_range(0, 3)); addr = 20'($urandom); wd = 8'($urandom);
      dir = 1'($urandom_range(0, 1));
      set_rdy($urandom_range(2, 8), $urandom_range(0, 6));
      ex = exit_of(TO_A);
      do_txn(0, cmd, addr, wd, dir, -1, ex + HOLD + 3, ok);
      e = model(TO_A, cmd, dir);
      m = measure(ex + HOLD + 3, cmd, exp_addr(cmd, addr), wd);
      checks++;
      if (!ok || m !== e) begin
        errors++; $display("FAIL random_%0d cmd=%0d: got %s want %s", n, cmd, fmt(m), fmt(e));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int rvs = 0, lows = 0;
    #1; req_valid = 1; req_cmd = ISA_IOW; req_addr = 20'h00378; req_wdata = 8'h55; bus_rdy = 1;
    wait_accept(0, ok);
    #1; req_valid = 0;
    @(posedge clk); @(posedge clk); #1 reset = 1;
    @(negedge clk);
    checks++; if (!ok || a_iow !== 1'b0) begin errors++; $display("FAIL midreset_pre: iow=%b want 0", a_iow); end
    @(posedge clk); @(negedge clk);
    checks++; if ({a_iow, a_aen, a_doe, a_rv} !== 4'b1100) begin
      errors++; $display("FAIL midreset_abort: iow=%b aen=%b oe=%b rv=%b want 1 1 0 0", a_iow, a_aen, a_doe, a_rv); end
    @(posedge clk); #1 reset = 0;
    repeat (8) begin
      @(negedge clk); if (a_rv !== 1'b0) rvs++; if (a_iow !== 1'b1) lows++;
    end
    checks++; if (rvs !== 0 || lows !== 0 || a_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_dropped: rv=%0d strobe=%0d ready=%b want 0 0 1", rvs, lows, a_ready); end
  endtask

  initial begin
    test_reset();
    test_iow();
    test_ior();
    test_wait_states();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    checks++;
    if (multi_low !== 0) begin
      errors++; $display("FAIL single_strobe: %0d cycles with several strobes low, want 0", multi_low);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
